aes_dec_iter_core: RTL

// Iterative AES inverse cipher (FIPS-197 InvCipher); one round per clock, decrypts one 128-bit block at a time.

---
 rtl/aes_dec_iter_core_if.sv | 29 ++
 rtl/aes_dec_iter_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_iter_core_if.sv
// aes_dec_iter_core_if
// Block and round-key bus of the iterative AES decrypt core. Signal names
// follow the core's point of view (in* = driven into the core).
//   inData/inValid/outReady      : ciphertext input handshake
//   outKeyIdx/inRoundKey         : round-key fetch, combinational read
//   outData/outValid/inReady     : plaintext output handshake
// Modports: slave = the core, master = the block feeding/draining it.
interface aes_dec_iter_core_if #(
  parameter int KEY_IDX_W = 4
);
  logic [127:0]         inData;
  logic                 inValid;
  logic                 outReady;
  logic [KEY_IDX_W-1:0] outKeyIdx;
  logic [127:0]         inRoundKey;
  logic [127:0]         outData;
  logic                 outValid;
  logic                 inReady;

  modport slave (
    input  inData, inValid, inRoundKey, inReady,
    output outReady, outKeyIdx, outData, outValid
  );

  modport master (
    output inData, inValid, inRoundKey, inReady,
    input  outReady, outKeyIdx, outData, outValid
  );
endinterface

// File: rtl/aes_dec_iter_core.sv
// aes_dec_iter_core
// Iterative AES inverse cipher, one round per clock, one 128-bit block in
// flight. Round keys are fetched by index from an external expanded-key
// store with a combinational read.
// Ports:
//   inClk : clock, rising edge
//   inRst : asynchronous active-high reset
//   bus   : aes_dec_iter_core_if.slave (block in, key fetch, block out)
// Byte 0 of a block is bits [127:120]; the state is column-major, so the
// byte at row r, column c sits at bits [127-8*(4c+r) -: 8].
//
// state | meaning
// IDLE  | outReady high; accept applies round key ROUNDS
// ROUND | cnt counts ROUNDS-1..0; round key index = cnt
// DONE  | outValid high, outData held until inReady
module aes_dec_iter_core #(
  parameter int ROUNDS    = 14,
  parameter int KEY_IDX_W = 4
) (
  input logic                inClk,
  input logic                inRst,
  aes_dec_iter_core_if.slave bus
);

  if (!(ROUNDS == 10 || ROUNDS == 12 || ROUNDS == 14) || ((2 ** KEY_IDX_W) <= ROUNDS)) begin : g_cfg_err
    $error("aes_dec_iter_core: illegal ROUNDS/KEY_IDX_W combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_e;

  localparam logic [KEY_IDX_W-1:0] LAST_IDX  = KEY_IDX_W'(ROUNDS);
  localparam logic [KEY_IDX_W-1:0] FIRST_CNT = KEY_IDX_W'(ROUNDS - 1);

  fsm_e                 fsm_q, fsm_d;
  logic [KEY_IDX_W-1:0] cnt_q, cnt_d;
  logic [127:0]         state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_ready_q, out_ready_d;
  logic [KEY_IDX_W-1:0] key_idx;
  logic [127:0]         round_tmp;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  // Inverse S-box computed algebraically: undo the affine map, then invert.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // InvShiftRows (row r rotates right by r) fused with InvSubBytes.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-8*(4*c+rw) -: 8] = inv_sbox(s[127-8*(4*((c-rw+4)%4)+rw) -: 8]);
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a, x2, x4, x8;
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        a     = s[127-8*(4*c+i) -: 8];
        x2    = xtime(a);
        x4    = xtime(x2);
        x8    = xtime(x4);
        m9[i] = x8 ^ a;
        mb[i] = x8 ^ x2 ^ a;
        md[i] = x8 ^ x4 ^ a;
        me[i] = x8 ^ x4 ^ x2;
      end
      r[127-32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                           m9[0] ^ me[1] ^ mb[2] ^ md[3],
                           md[0] ^ m9[1] ^ me[2] ^ mb[3],
                           mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end
    return r;
  endfunction

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    key_idx   = LAST_IDX;
    round_tmp = inv_shift_sub(state_q) ^ bus.inRoundKey;
    unique case (fsm_q)
      ST_IDLE: begin
        if (bus.inValid && out_ready_q) begin
          state_d = bus.inData ^ bus.inRoundKey;
          cnt_d   = FIRST_CNT;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        key_idx = cnt_q;
        if (cnt_q == '0) begin
          state_d = round_tmp;
          fsm_d   = ST_DONE;
        end else begin
          state_d = inv_mix_columns(round_tmp);
          cnt_d   = cnt_q - KEY_IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.inReady) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
    // Both flags are registered copies of the next state, so they change on
    // the same edge as the FSM and DONE can never accept a block.
    out_ready_d = (fsm_d == ST_IDLE);
    out_valid_d = (fsm_d == ST_DONE);
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= '0;
      state_q     <= '0;
      out_valid_q <= 1'b0;
      out_ready_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_ready_q <= out_ready_d;
    end
  end

  assign bus.outReady  = out_ready_q;
  assign bus.outValid  = out_valid_q;
  assign bus.outKeyIdx = key_idx;
  // Intermediate round states never reach the output.
  assign bus.outData   = out_valid_q ? state_q : '0;

endmodule
